// File: rtl/tl_pkg.sv
// Shared constants and types for the traffic-light agent/environment pair.
// Contents:
//   LANE_W, N_LANES, ACT_W, STATE_W  - lane-state and action geometry
//   tl_state_t                       - policy FSM states (IDLE, DECIDE, HOLD)
//   lane_field()                     - extracts one lane's congestion field from S
package tl_pkg;

    localparam int LANE_W  = 3;
    localparam int N_LANES = 4;
    localparam int ACT_W   = 2;
    localparam int STATE_W = LANE_W * N_LANES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        HOLD   = 2'd2
    } tl_state_t;

    // Lane idx occupies S[idx*LANE_W +: LANE_W]; lane 0 sits in the low bits.
    function automatic logic [LANE_W-1:0] lane_field(
        input logic [STATE_W-1:0] s,
        input logic [ACT_W-1:0]   idx
    );
        return s[int'(idx) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
// Steps on every clock edge outside reset; it is the randomness source for
// exploratory actions.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset, loads SEED
//   q    out  current LFSR state
// SEED must be nonzero, otherwise the register locks up at zero.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // Right-shifting Galois form: taps for x^16, x^14, x^13, x^11 land on
    // bits 15, 13, 12, 10 and are toggled whenever a 1 shifts out.
    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = {1'b0, lfsr_reg[15:1]};
        if (lfsr_reg[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/action_selector.sv
// Policy block of the traffic-light agent. Picks the green lane from the
// 12-bit congestion state S: greedily the most congested lane, or, while
// learning, occasionally a pseudo-random lane (epsilon-greedy). Each action
// is held for MIN_HOLD cycles before the next decision.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   run request; decisions are made while high
//   learning    in   1 = epsilon-greedy, 0 = pure greedy
//   S[11:0]     in   lane congestion, 3 bits per lane, lane 0 in S[2:0]
//   A[1:0]      out  current action (lane given green), registered
//   a_valid     out  high while the action is being held
//   a_new       out  one-cycle pulse in the first hold cycle of a decision
//   explore     out  1 when the current A came from the random path
//   switch_cnt  out  saturating count of decisions that changed A
module action_selector
    import tl_pkg::*;
#(
    parameter int unsigned MIN_HOLD   = 4,
    parameter logic [7:0]  EPS_THRESH = 8'd26,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               learning,
    input  logic [STATE_W-1:0] S,
    output logic [ACT_W-1:0]   A,
    output logic               a_valid,
    output logic               a_new,
    output logic               explore,
    output logic [7:0]         switch_cnt
);

    localparam int                HOLD_W    = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

    tl_state_t           state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [ACT_W-1:0]    a_reg, a_next;
    logic                explore_reg, explore_next;
    logic [7:0]          switch_cnt_reg, switch_cnt_next;

    logic [15:0]         lfsr_q;
    logic                lfsr_unused;
    logic [LANE_W-1:0]   lane [N_LANES];
    logic [LANE_W-1:0]   greedy_max;
    logic [ACT_W-1:0]    greedy_idx;
    logic                take_random;
    logic [ACT_W-1:0]    decision;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low ten LFSR bits drive the policy (threshold byte + lane).
    assign lfsr_unused = ^lfsr_q[15:10];

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        assign lane[gi] = lane_field(S, ACT_W'(gi));
    end

    // Strict '>' keeps the earliest lane on ties, so equal congestion
    // resolves to the lowest index.
    always_comb begin
        greedy_max = lane[0];
        greedy_idx = '0;
        for (int i = 1; i < N_LANES; i++) begin
            if (lane[i] > greedy_max) begin
                greedy_max = lane[i];
                greedy_idx = ACT_W'(i);
            end
        end
    end

    assign take_random = learning && (lfsr_q[7:0] < EPS_THRESH);
    assign decision    = take_random ? lfsr_q[9:8] : greedy_idx;

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        a_next          = a_reg;
        explore_next    = explore_reg;
        switch_cnt_next = switch_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                a_next        = decision;
                explore_next  = take_random;
                hold_cnt_next = '0;
                if ((decision != a_reg) && (switch_cnt_reg != 8'hFF)) begin
                    switch_cnt_next = switch_cnt_reg + 8'd1;
                end
                state_next = HOLD;
            end
            HOLD: begin
                // A started hold always runs to completion; en only decides
                // what follows it.
                hold_cnt_next = hold_cnt_reg + 1'b1;
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = en ? DECIDE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            a_reg          <= '0;
            explore_reg    <= 1'b0;
            switch_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            a_reg          <= a_next;
            explore_reg    <= explore_next;
            switch_cnt_reg <= switch_cnt_next;
        end
    end

    assign A          = a_reg;
    assign explore    = explore_reg;
    assign switch_cnt = switch_cnt_reg;
    assign a_valid    = (state_reg == HOLD);
    assign a_new      = (state_reg == HOLD) && (hold_cnt_reg == '0);

endmodule
